icache_port_arbiter: RTL

- Shares the single i-cache read port between two requesters:
  - the IFU demand path, which is the IFU read request/done pair;
  - the next-line prefetcher.
- Sits between the IFU/prefetcher and the i-cache interface.
- Keeps at most one read outstanding, gives demand priority, and guarantees prefetch forward progress with a starvation counter.
- Handles flushes by draining and discarding any in-flight response.

---
 rtl/icache_port_arbiter_if.sv | 59 +++++
 rtl/icache_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/icache_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | icache_port_arbiter_if : IFU/prefetcher/i-cache bus for the arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface icache_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            dem_req_i;
  logic [XLEN-1:0] dem_addr_i;
  logic            dem_gnt_o;
  logic            dem_done_o;
  logic            pf_req_i;
  logic [XLEN-1:0] pf_addr_i;
  logic            pf_gnt_o;
  logic            pf_done_o;
  logic            icache_req_o;
  logic [XLEN-1:0] icache_addr_o;
  logic            icache_ready_i;
  logic            icache_valid_i;

  // Arbiter side
  modport slave (
    input  flush_i,
    input  dem_req_i,
    input  dem_addr_i,
    output dem_gnt_o,
    output dem_done_o,
    input  pf_req_i,
    input  pf_addr_i,
    output pf_gnt_o,
    output pf_done_o,
    output icache_req_o,
    output icache_addr_o,
    input  icache_ready_i,
    input  icache_valid_i
  );

  // Requester / cache-model side
  modport master (
    output flush_i,
    output dem_req_i,
    output dem_addr_i,
    input  dem_gnt_o,
    input  dem_done_o,
    output pf_req_i,
    output pf_addr_i,
    input  pf_gnt_o,
    input  pf_done_o,
    input  icache_req_o,
    input  icache_addr_o,
    output icache_ready_i,
    output icache_valid_i
  );
endinterface

`default_nettype wire

// File: rtl/icache_port_arbiter.sv
// +----------------------------------------------------------------------+
// | icache_port_arbiter : shares the i-cache read port, demand first      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module icache_port_arbiter #(
  parameter int XLEN          = 32,
  parameter int LINE_OFFSET   = 4,
  parameter int PF_STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  icache_port_arbiter_if.slave bus
);

  localparam int              CNT_W     = $clog2(PF_STARVE_MAX + 1);
  localparam int              TAG_W     = XLEN - LINE_OFFSET;
  localparam logic [XLEN-1:0] LINE_MASK = XLEN'((64'd1 << LINE_OFFSET) - 64'd1);
  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(PF_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DEM = 2'd1,
    WAIT_PF  = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [TAG_W-1:0] pf_line_q,  pf_line_d;
  logic             promoted_q, promoted_d;
  logic [CNT_W-1:0] starve_q,   starve_d;

  logic            w_pf_force;
  logic            w_pf_wins;
  logic [XLEN-1:0] w_win_addr;
  logic            w_promote;

  logic            w_icache_req;
  logic [XLEN-1:0] w_icache_addr;
  logic            w_dem_gnt;
  logic            w_dem_done;
  logic            w_pf_gnt;
  logic            w_pf_done;

  // Starvation override beats demand priority
  assign w_pf_force = bus.pf_req_i && (starve_q == STARVE_MAX_C);
  assign w_pf_wins  = w_pf_force || (bus.pf_req_i && !bus.dem_req_i);
  assign w_win_addr = w_pf_wins ? bus.pf_addr_i : bus.dem_addr_i;

  // A demand hitting the line already being prefetched rides on that read
  assign w_promote  = bus.dem_req_i && !promoted_q &&
                      (bus.dem_addr_i[XLEN-1:LINE_OFFSET] == pf_line_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pf_line_q  <= '0;
      promoted_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      pf_line_q  <= pf_line_d;
      promoted_q <= promoted_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pf_line_d     = pf_line_q;
    promoted_d    = promoted_q;
    starve_d      = starve_q;
    w_icache_req  = 1'b0;
    w_icache_addr = '0;
    w_dem_gnt     = 1'b0;
    w_dem_done    = 1'b0;
    w_pf_gnt      = 1'b0;
    w_pf_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.flush_i && (bus.dem_req_i || bus.pf_req_i)) begin
          w_icache_req  = 1'b1;
          w_icache_addr = w_win_addr & ~LINE_MASK;
          if (bus.icache_ready_i) begin
            if (w_pf_wins) begin
              w_pf_gnt  = 1'b1;
              pf_line_d = bus.pf_addr_i[XLEN-1:LINE_OFFSET];
              state_d   = WAIT_PF;
            end else begin
              w_dem_gnt = 1'b1;
              state_d   = WAIT_DEM;
            end
          end
        end
      end

      WAIT_DEM: begin
        if (bus.flush_i) begin
          state_d = bus.icache_valid_i ? IDLE : DRAIN;
        end else if (bus.icache_valid_i) begin
          w_dem_done = 1'b1;
          state_d    = IDLE;
        end
      end

      WAIT_PF: begin
        if (bus.flush_i) begin
          state_d = bus.icache_valid_i ? IDLE : DRAIN;
        end else begin
          w_dem_gnt = w_promote;
          if (bus.icache_valid_i) begin
            w_pf_done  = 1'b1;
            w_dem_done = promoted_q || w_promote;
            promoted_d = 1'b0;
            state_d    = IDLE;
          end else if (w_promote) begin
            promoted_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (bus.icache_valid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      promoted_d = 1'b0;
    end

    // Counts every demand grant (issue or promotion) made while a prefetch waits
    if (bus.flush_i || !bus.pf_req_i || w_pf_gnt) begin
      starve_d = '0;
    end else if (w_dem_gnt && (starve_q != STARVE_MAX_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign bus.icache_req_o  = w_icache_req;
  assign bus.icache_addr_o = w_icache_addr;
  assign bus.dem_gnt_o     = w_dem_gnt;
  assign bus.dem_done_o    = w_dem_done;
  assign bus.pf_gnt_o      = w_pf_gnt;
  assign bus.pf_done_o     = w_pf_done;

endmodule

`default_nettype wire
